// File: rtl/paula_audio_pkg.sv
// ============================================================================
// Module   : paula_audio_pkg
// Purpose  : Shared widths, state encoding and volume clamp for one Paula
//            audio channel sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package paula_audio_pkg;

  localparam int c_SMP_W = 8;
  localparam int c_VOL_W = 6;
  localparam int c_PER_W = 16;
  localparam int c_LEN_W = 16;

  localparam logic [c_VOL_W-1:0] c_VOL_MAX = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_HI    = 2'd2,
    ST_LO    = 2'd3
  } state_t;

  // Bit 6 forces full scale regardless of the low six bits.
  function automatic logic [c_VOL_W-1:0] vol_clamp(input logic [6:0] i_v);
    return i_v[6] ? c_VOL_MAX : i_v[5:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/paula_audio_pertimer.sv
// ============================================================================
// Module   : paula_audio_pertimer
// Purpose  : Colour-clock period down-counter; a period of 0 behaves as 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module paula_audio_pertimer
  import paula_audio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_cck_en,
  input  logic [c_PER_W-1:0] i_period,
  output logic               o_expire
);

  logic [c_PER_W-1:0] r_cnt;
  logic [c_PER_W-1:0] w_reload;

  assign w_reload = (i_period == '0) ? c_PER_W'(1) : i_period;

  // The counter parks at 1 so an unreloaded (underrun) period keeps expiring.
  assign o_expire = i_cck_en && (r_cnt <= c_PER_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_reload;
    end else if (i_cck_en && (r_cnt > c_PER_W'(1))) begin
      r_cnt <= r_cnt - c_PER_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/paula_audio_sequencer.sv
// ============================================================================
// Module   : paula_audio_sequencer
// Purpose  : Per-channel Paula audio sequencer: DMA word buffering, byte
//            playback at the programmed period, DMA requests and block IRQs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module paula_audio_sequencer
  import paula_audio_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cck_en,
  input  logic               dmaena,
  input  logic               per_wr,
  input  logic               len_wr,
  input  logic               vol_wr,
  input  logic [15:0]        reg_data,
  input  logic               dat_wr,
  input  logic [15:0]        dat_data,
  output logic               dmareq,
  output logic               intreq,
  output logic [c_SMP_W-1:0] sample,
  output logic [c_VOL_W-1:0] volume
);

  state_t             r_state;
  logic [c_PER_W-1:0] r_per;
  logic [c_LEN_W-1:0] r_len;
  logic [c_LEN_W-1:0] r_len_cnt;
  logic [15:0]        r_buf;
  logic [15:0]        r_hold;
  logic               r_hold_valid;
  logic               r_under;
  logic               r_dmareq;
  logic               r_intreq;
  logic [c_SMP_W-1:0] r_sample;
  logic [c_VOL_W-1:0] r_volume;

  logic               w_acc;
  logic               w_expire;
  logic               w_load;
  logic [c_PER_W-1:0] w_per_eff;
  logic [c_LEN_W-1:0] w_len_eff;

  assign w_acc     = dat_wr && r_dmareq;
  // A register write landing on a reload cycle is used immediately.
  assign w_per_eff = per_wr ? reg_data : r_per;
  assign w_len_eff = len_wr ? reg_data : r_len;

  assign dmareq = r_dmareq;
  assign intreq = r_intreq;
  assign sample = r_sample;
  assign volume = r_volume;

  always_comb begin
    w_load = 1'b0;
    if (dmaena) begin
      case (r_state)
        ST_FIRST: w_load = w_acc;
        ST_HI:    w_load = w_expire;
        ST_LO:    w_load = (w_expire && r_hold_valid) ||
                           (w_acc && !r_hold_valid && (w_expire || r_under));
        default:  w_load = 1'b0;
      endcase
    end
  end

  paula_audio_pertimer u_pertimer (
    .clk      (clk),
    .rst      (reset),
    .i_load   (w_load),
    .i_cck_en (cck_en),
    .i_period (w_per_eff),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_per    <= '0;
      r_len    <= '0;
      r_volume <= '0;
    end else begin
      if (per_wr) r_per <= reg_data;
      if (len_wr) r_len <= reg_data;
      if (vol_wr) r_volume <= vol_clamp(reg_data[6:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_len_cnt    <= '0;
      r_buf        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_under      <= 1'b0;
      r_dmareq     <= 1'b0;
      r_intreq     <= 1'b0;
      r_sample     <= '0;
    end else if (!dmaena) begin
      r_state      <= ST_IDLE;
      r_hold_valid <= 1'b0;
      r_under      <= 1'b0;
      r_dmareq     <= 1'b0;
      r_intreq     <= 1'b0;
      r_sample     <= '0;
    end else begin
      r_intreq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sample  <= '0;
          r_len_cnt <= w_len_eff;
          r_dmareq  <= 1'b1;
          r_state   <= ST_FIRST;
        end
        ST_FIRST: begin
          if (w_acc) begin
            r_buf     <= dat_data;
            r_sample  <= dat_data[15:8];
            r_len_cnt <= w_len_eff;
            r_dmareq  <= 1'b0;
            r_intreq  <= 1'b1;
            r_state   <= ST_HI;
          end
        end
        ST_HI: begin
          if (w_expire) begin
            r_sample <= r_buf[7:0];
            r_dmareq <= 1'b1;
            r_state  <= ST_LO;
          end
        end
        ST_LO: begin
          // A counter value of 1 marks the word that opens the next block.
          if (w_acc) begin
            if (r_len_cnt == c_LEN_W'(1)) begin
              r_len_cnt <= w_len_eff;
              r_intreq  <= 1'b1;
            end else begin
              r_len_cnt <= r_len_cnt - c_LEN_W'(1);
            end
          end
          if (w_expire && r_hold_valid) begin
            r_buf        <= r_hold;
            r_sample     <= r_hold[15:8];
            r_hold_valid <= 1'b0;
            r_state      <= ST_HI;
          end else if (w_acc && (w_expire || r_under)) begin
            r_buf    <= dat_data;
            r_sample <= dat_data[15:8];
            r_dmareq <= 1'b0;
            r_under  <= 1'b0;
            r_state  <= ST_HI;
          end else begin
            if (w_acc) begin
              r_hold       <= dat_data;
              r_hold_valid <= 1'b1;
              r_dmareq     <= 1'b0;
            end
            if (w_expire) r_under <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_paula_audio_sequencer.sv
// ============================================================================
// Module   : tb_paula_audio_sequencer
// Purpose  : Directed self-checking bench for paula_audio_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_paula_audio_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cck_en;
  logic        dmaena;
  logic        per_wr;
  logic        len_wr;
  logic        vol_wr;
  logic [15:0] reg_data;
  logic        dat_wr;
  logic [15:0] dat_data;
  logic        dmareq;
  logic        intreq;
  logic [7:0]  sample;
  logic [5:0]  volume;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  paula_audio_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .cck_en   (cck_en),
    .dmaena   (dmaena),
    .per_wr   (per_wr),
    .len_wr   (len_wr),
    .vol_wr   (vol_wr),
    .reg_data (reg_data),
    .dat_wr   (dat_wr),
    .dat_data (dat_data),
    .dmareq   (dmareq),
    .intreq   (intreq),
    .sample   (sample),
    .volume   (volume)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = period, 1 = length, 2 = volume
  task automatic wr_reg(input int which, input logic [15:0] d);
    reg_data = d;
    per_wr   = (which == 0);
    len_wr   = (which == 1);
    vol_wr   = (which == 2);
    tick();
    per_wr = 1'b0;
    len_wr = 1'b0;
    vol_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cck_en = 1'b0; dmaena = 1'b0;
    per_wr = 1'b0; len_wr = 1'b0; vol_wr = 1'b0;
    reg_data = '0; dat_wr = 1'b0; dat_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (dmareq !== 1'b0) begin n_fail++; $display("FAIL rst_dmareq got=%b exp=0", dmareq); end
    n_tests++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL rst_intreq got=%b exp=0", intreq); end
    n_tests++; if (sample !== 8'h00) begin n_fail++; $display("FAIL rst_sample got=%h exp=00", sample); end
    n_tests++; if (volume !== 6'd0) begin n_fail++; $display("FAIL rst_volume got=%0d exp=0", volume); end
  endtask

  task automatic test_first_block();
    do_reset();
    wr_reg(0, 16'd3);
    wr_reg(1, 16'd2);
    cck_en = 1'b1; dmaena = 1'b1;
    tick();
    n_tests++; if (dmareq !== 1'b1) begin n_fail++; $display("FAIL t1_dmareq_rise got=%b exp=1", dmareq); end
    dat_wr = 1'b1; dat_data = 16'h7F80;
    tick();
    dat_wr = 1'b0;
    n_tests++; if (intreq !== 1'b1) begin n_fail++; $display("FAIL t1_intreq got=%b exp=1", intreq); end
    n_tests++; if (dmareq !== 1'b0) begin n_fail++; $display("FAIL t1_dmareq_fall got=%b exp=0", dmareq); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (sample !== 8'h7F) begin n_fail++; $display("FAIL t1_hi[%0d] sample=%h exp=7f", i, sample); end
      if (i > 0) begin
        n_tests++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL t1_intreq_once[%0d] got=%b exp=0", i, intreq); end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (sample !== 8'h80) begin n_fail++; $display("FAIL t1_lo[%0d] sample=%h exp=80", i, sample); end
      n_tests++; if (dmareq !== 1'b1) begin n_fail++; $display("FAIL t1_lo_dmareq[%0d] got=%b exp=1", i, dmareq); end
      tick();
    end
  endtask

  // Continues from test_first_block: channel sits in LO with no word pending.
  task automatic test_underrun();
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (sample !== 8'h80) begin n_fail++; $display("FAIL t3_hold[%0d] sample=%h exp=80", i, sample); end
      n_tests++; if (dmareq !== 1'b1) begin n_fail++; $display("FAIL t3_dmareq[%0d] got=%b exp=1", i, dmareq); end
      tick();
    end
    dat_wr = 1'b1; dat_data = 16'h1234;
    tick();
    dat_wr = 1'b0;
    n_tests++; if (sample !== 8'h12) begin n_fail++; $display("FAIL t3_resume sample=%h exp=12", sample); end
    n_tests++; if (dmareq !== 1'b0) begin n_fail++; $display("FAIL t3_resume_dmareq got=%b exp=0", dmareq); end
    n_tests++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL t3_resume_intreq got=%b exp=0", intreq); end
  endtask

  task automatic test_block_reload();
    logic [15:0] words [3];
    logic [7:0]  exp_s [6];
    logic [7:0]  got [$];
    int          irq_at [$];
    logic [7:0]  prev;
    int          widx;
    words = '{16'h0102, 16'h0304, 16'h0506};
    exp_s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    prev = 8'h00;
    widx = 0;
    do_reset();
    wr_reg(0, 16'd2);
    wr_reg(1, 16'd2);
    cck_en = 1'b1; dmaena = 1'b1;
    for (int c = 0; c < 60; c++) begin
      dat_wr   = dmareq && (widx < 3);
      dat_data = (widx < 3) ? words[widx] : 16'h0000;
      tick();
      if (dat_wr) widx++;
      if (intreq === 1'b1) irq_at.push_back(widx);
      if (sample !== prev) begin got.push_back(sample); prev = sample; end
    end
    dat_wr = 1'b0;
    n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL t2_seq_len got=%0d exp=6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        n_tests++; if (got[i] !== exp_s[i]) begin n_fail++; $display("FAIL t2_seq[%0d] got=%h exp=%h", i, got[i], exp_s[i]); end
      end
    end
    n_tests++; if (irq_at.size() != 2) begin n_fail++; $display("FAIL t2_irq_count got=%0d exp=2", irq_at.size()); end
    if (irq_at.size() >= 2) begin
      n_tests++; if (irq_at[0] != 1) begin n_fail++; $display("FAIL t2_irq0 word=%0d exp=1", irq_at[0]); end
      n_tests++; if (irq_at[1] != 3) begin n_fail++; $display("FAIL t2_irq1 word=%0d exp=3", irq_at[1]); end
    end
  endtask

  task automatic test_volume();
    logic [15:0] vin  [5];
    logic [5:0]  vexp [5];
    vin  = '{16'd64, 16'h0025, 16'h0000, 16'h003F, 16'hFF41};
    vexp = '{6'd63, 6'd37, 6'd0, 6'd63, 6'd63};
    for (int i = 0; i < 5; i++) begin
      wr_reg(2, vin[i]);
      n_tests++; if (volume !== vexp[i]) begin n_fail++; $display("FAIL t4_vol[%0d] got=%0d exp=%0d", i, volume, vexp[i]); end
    end
  endtask

  task automatic test_cck_gating();
    int cnt;
    do_reset();
    wr_reg(0, 16'd2);
    wr_reg(1, 16'd1);
    cck_en = 1'b1; dmaena = 1'b1;
    tick();
    dat_wr = 1'b1; dat_data = 16'hABCD; cck_en = 1'b0;
    tick();
    dat_wr = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && sample === 8'hAB; c++) begin
      cnt++;
      cck_en = ~cck_en;
      tick();
    end
    n_tests++; if (cnt != 3) begin n_fail++; $display("FAIL t7_gated_hi_cycles got=%0d exp=3", cnt); end
    n_tests++; if (sample !== 8'hCD) begin n_fail++; $display("FAIL t7_gated_lo sample=%h exp=cd", sample); end
  endtask

  task automatic test_stop_restart();
    do_reset();
    wr_reg(0, 16'd3);
    wr_reg(1, 16'd2);
    cck_en = 1'b1; dmaena = 1'b1;
    tick();
    dat_wr = 1'b1; dat_data = 16'hA1B2;
    tick();
    dat_wr = 1'b0;
    for (int c = 0; c < 20 && dmareq !== 1'b1; c++) tick();
    n_tests++; if (dmareq !== 1'b1) begin n_fail++; $display("FAIL t5_lo_timeout dmareq=%b exp=1", dmareq); end
    n_tests++; if (sample !== 8'hB2) begin n_fail++; $display("FAIL t5_lo sample=%h exp=b2", sample); end
    dat_wr = 1'b1; dat_data = 16'hC3D4;
    tick();
    dat_wr = 1'b0;
    n_tests++; if (dmareq !== 1'b0) begin n_fail++; $display("FAIL t5_hold_dmareq got=%b exp=0", dmareq); end
    dmaena = 1'b0;
    tick();
    n_tests++; if (sample !== 8'h00) begin n_fail++; $display("FAIL t5_stop_sample got=%h exp=00", sample); end
    n_tests++; if (dmareq !== 1'b0) begin n_fail++; $display("FAIL t5_stop_dmareq got=%b exp=0", dmareq); end
    wr_reg(0, 16'd0);
    dmaena = 1'b1;
    tick();
    n_tests++; if (dmareq !== 1'b1) begin n_fail++; $display("FAIL t5_restart_dmareq got=%b exp=1", dmareq); end
    dat_wr = 1'b1; dat_data = 16'h1122;
    tick();
    dat_wr = 1'b0;
    n_tests++; if (sample !== 8'h11) begin n_fail++; $display("FAIL t5_p0_hi sample=%h exp=11", sample); end
    n_tests++; if (intreq !== 1'b1) begin n_fail++; $display("FAIL t5_restart_intreq got=%b exp=1", intreq); end
    tick();
    n_tests++; if (sample !== 8'h22) begin n_fail++; $display("FAIL t5_p0_lo sample=%h exp=22", sample); end
    n_tests++; if (dmareq !== 1'b1) begin n_fail++; $display("FAIL t5_p0_dmareq got=%b exp=1", dmareq); end
    dat_wr = 1'b1; dat_data = 16'h3344;
    tick();
    dat_wr = 1'b0;
    n_tests++; if (sample !== 8'h33) begin n_fail++; $display("FAIL t5_bypass sample=%h exp=33", sample); end
    tick();
    n_tests++; if (sample !== 8'h44) begin n_fail++; $display("FAIL t5_bypass_lo sample=%h exp=44", sample); end
  endtask

  task automatic test_reset_mid_hi();
    do_reset();
    wr_reg(2, 16'h0020);
    wr_reg(0, 16'd3);
    wr_reg(1, 16'd2);
    cck_en = 1'b1; dmaena = 1'b1;
    tick();
    dat_wr = 1'b1; dat_data = 16'h5566;
    tick();
    dat_wr = 1'b0;
    n_tests++; if (sample !== 8'h55) begin n_fail++; $display("FAIL t6_hi sample=%h exp=55", sample); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (sample !== 8'h00) begin n_fail++; $display("FAIL t6_rst_sample got=%h exp=00", sample); end
    n_tests++; if (dmareq !== 1'b0) begin n_fail++; $display("FAIL t6_rst_dmareq got=%b exp=0", dmareq); end
    n_tests++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL t6_rst_intreq got=%b exp=0", intreq); end
    n_tests++; if (volume !== 6'd0) begin n_fail++; $display("FAIL t6_rst_volume got=%0d exp=0", volume); end
    dat_wr = 1'b1; dat_data = 16'h9900;
    tick();
    dat_wr = 1'b0;
    n_tests++; if (dmareq !== 1'b1) begin n_fail++; $display("FAIL t6_req got=%b exp=1", dmareq); end
    tick();
    n_tests++; if (sample !== 8'h00) begin n_fail++; $display("FAIL t6_ignored sample=%h exp=00", sample); end
    n_tests++; if (intreq !== 1'b0) begin n_fail++; $display("FAIL t6_ignored_intreq got=%b exp=0", intreq); end
    dat_wr = 1'b1; dat_data = 16'h7788;
    tick();
    dat_wr = 1'b0;
    n_tests++; if (sample !== 8'h77) begin n_fail++; $display("FAIL t6_accept sample=%h exp=77", sample); end
  endtask

  initial begin
    test_reset();
    test_first_block();
    test_underrun();
    test_block_reload();
    test_volume();
    test_cck_gating();
    test_stop_restart();
    test_reset_mid_hi();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/paula_audio_sequencer.md
# paula_audio_sequencer

Per-channel Paula audio sequencer: accepts DMA-delivered 16-bit sample words and AUDxPER/AUDxLEN/AUDxVOL register writes, then plays each word as two signed 8-bit samples at the programmed colour-clock period. It drives the `sample`/`volume` inputs of the channel's volume multiplier. It also issues DMA requests for the next word and an interrupt at each block start. One instance per channel, four in Paula.

## Interface
Parameters:
- none

Ports, listed as name, direction, width, meaning:
- `clk`, in, 1, system clock. Single clock; everything updates on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `cck_en`, in, 1, colour-clock enable. The period counter advances only on cycles where it is 1.
- `dmaena`, in, 1, channel DMA enable.
- `per_wr`, in, 1, write strobe for the period register.
- `len_wr`, in, 1, write strobe for the length register.
- `vol_wr`, in, 1, write strobe for the volume register.
- `reg_data`, in, 16, register write data.
- `dat_wr`, in, 1, DMA data strobe. Accepted only while `dmareq`=1.
- `dat_data`, in, 16, DMA word. Bits [15:8] form the first sample, bits [7:0] the second.
- `dmareq`, out, 1, registered request for one DMA word.
- `intreq`, out, 1, one-cycle block-start interrupt pulse.
- `sample`, out, 8, signed sample, to the multiplier.
- `volume`, out, 6, unsigned volume, to the multiplier.

## Operation
Registers `per_reg`, `len_reg` and `vol_reg` all reset to 0.
- Volume: `vol_reg` takes `reg_data[6:0]`. `volume` = 63 if bit 6 is set, else bits [5:0].
- Period: a `per_reg` value of 0 is treated as 1.
- Length: a `len_reg` value of 0 means 65536 words.

State machine: IDLE, FIRST, HI, LO.
- IDLE
  - `sample`=0, `dmareq`=0.
  - If `dmaena`=1: load the length counter from `len_reg`, set `dmareq`, go to FIRST.
- FIRST
  - On an accepted `dat_wr`: load `buf`, clear `dmareq`, pulse `intreq`, reload the period counter, go to HI.
- HI
  - `sample`=`buf[15:8]`.
  - When the period expires (counter reaches 1 on a `cck_en` cycle): reload the counter, go to LO, set `dmareq`.
- LO
  - `sample`=`buf[7:0]`.
  - An accepted `dat_wr` loads `hold`, sets `hold_valid` and clears `dmareq`.
  - On period expiry with `hold_valid`=1: move `hold` to `buf`, clear `hold_valid`, go to HI.

Length counter:
- Decrements on every accepted `dat_wr`.
- When an accepted `dat_wr` finds the counter at 1, it reloads from `len_reg` and pulses `intreq` (the next word starts a new block).
- The first word in FIRST also loads the counter and pulses `intreq`.

Boundary rules:
- **Underrun.** Period expiry in LO with `hold_valid`=0: stay in LO, keep `sample`, keep `dmareq`=1. The period counter is not reloaded. On the cycle after the `dat_wr` is accepted, go to HI with the new word and reload the period counter.
- **`dat_wr` on the expiry cycle.** A `dat_wr` in the same cycle as LO expiry with `hold` empty bypasses `hold`: the word goes straight to `buf` and the state goes to HI.
- **`dat_wr` while `dmareq`=0.** Ignored.
- **`dmaena` falling in any state.** Next cycle: IDLE, `sample`=0, `dmareq`=0, `hold_valid`=0. A pending `intreq` pulse is suppressed.
- **`per_wr` / `len_wr` mid-play.** They take effect at the next reload. If a write coincides with the reload cycle, the new value is used.
- **`reset` at any time.** Next cycle: IDLE, all registers 0.

## Timing
- Reset values: `dmareq`=0, `intreq`=0, `sample`=0, `volume`=0.
- All outputs are registered.
- `dmareq` rises one cycle after `dmaena` is first seen high in IDLE.
- `dmareq` rises one cycle after the HI→LO expiry.
- `dmareq` falls one cycle after the accepted `dat_wr`.
- `sample` changes one cycle after the expiry edge (or after the accepted `dat_wr` when leaving FIRST).
- `intreq` goes high one cycle after the qualifying `dat_wr` and lasts exactly one `clk` cycle.
- Each byte is output for `per_reg` × (`cck_en` pulses) cycles, plus any underrun stall.
- `volume` follows `vol_wr` with one cycle of latency.

## Structure
- Package `paula_audio_pkg` holds:
  - the state encoding (IDLE/FIRST/HI/LO);
  - the width constants: sample 8, volume 6, period 16, length 16;
  - the volume clamp constant 63.
- Sub-module `paula_audio_pertimer`: 16-bit down-counter with `load`, `cck_en` and `expire` outputs, and zero-as-one handling.
- The word buffer, the `hold` register and the FSM stay in the top level.

## Test plan
1. **First block start.** `len`=2, `per`=3, `cck_en` every cycle, `dmaena` rises, word 0x7F80 delivered.
   - `intreq` pulses once.
   - `sample` = 0x7F for 3 cycles, then 0x80 for 3 cycles.
   - `dmareq` reasserts on entry to LO.
2. **Block reload.** `len`=2, continuous supply of words 0x0102, 0x0304, 0x0506.
   - Sample sequence 01 02 03 04 05 06.
   - `intreq` pulses after words 1 and 3 only.
3. **Underrun.** Withhold `dat_wr` for 10 cycles past LO expiry.
   - `sample` holds the low byte and `dmareq` stays 1.
   - HI begins one cycle after `dat_wr`.
4. **Volume clamp.** `vol_wr` with 64 → `volume`=63. With 0x25 → 37. With 0 → 0.
5. **Mid-operation stop and zero registers.** Drop `dmaena` in LO with `hold_valid`=1 → next cycle `sample`=0, `dmareq`=0. Then re-enable with `per`=0 → each byte is held exactly 1 `cck_en`.
6. **Reset mid-HI.** Assert `reset` during HI → all outputs 0 next cycle. A `dat_wr` arriving with `dmareq`=0 is ignored.
